// File: rtl/helios_stream_arbiter_pkg.sv
// Shared types and constants for the Helios stream arbiter.
package helios_stream_arbiter_pkg;

    localparam int unsigned FRAME_LEN_WIDTH = 8;
    localparam int unsigned BYTE_WIDTH      = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_HDR  = 3'd1,
        REQ_BODY = 3'd2,
        RSP_HDR  = 3'd3,
        RSP_BODY = 3'd4
    } arb_state_t;

    // Index width for n channels, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/helios_stream_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first requesting channel at or above the
// pointer, wrapping around. Purely combinational.
module rr_priority_picker
    import helios_stream_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [idx_width(NUM_REQ)-1:0]   rr_ptr_i,
    output logic [idx_width(NUM_REQ)-1:0]   grant_o,
    output logic                            any_req_o
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    // Scan upward from the pointer and keep the first hit.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_o   = '0;
        any_req_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_i) + i) % NUM_REQ;
            if (!any_req_o && req_i[IDX_W'(idx)]) begin
                any_req_o = 1'b1;
                grant_o   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/helios_stream_arbiter.sv
// Helios stream arbiter: shares one decoder byte stream between NUM_REQ
// host channels, one whole request/response transaction at a time.
// Optional response-header watchdog: define ARB_TIMEOUT_EN.
module helios_stream_arbiter
    import helios_stream_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BYTE_WIDTH*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [BYTE_WIDTH-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [BYTE_WIDTH-1:0]           dec_input_data,
    output logic                            dec_input_valid,
    input  logic                            dec_input_ready,
    input  logic [BYTE_WIDTH-1:0]           dec_output_data,
    input  logic                            dec_output_valid,
    output logic                            dec_output_ready,
    output logic [idx_width(NUM_REQ)-1:0]   owner,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("helios_stream_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t                 state_q;
    logic [IDX_W-1:0]           owner_q;
    logic [IDX_W-1:0]           rr_ptr_q;
    logic [FRAME_LEN_WIDTH-1:0] cnt_q;
    logic                       busy_q;

    logic [IDX_W-1:0]           grant_idx;
    logic [IDX_W-1:0]           rr_next;
    logic                       any_req;
    logic                       in_req;
    logic                       in_rsp;
    logic                       req_xfer;
    logic                       rsp_xfer;
    logic [BYTE_WIDTH-1:0]      req_bytes [NUM_REQ];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = idx_width(TIMEOUT_CYCLES);
    logic [TMO_W-1:0]           tmo_q;
    logic                       timeout_err_q;
`endif

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i     (req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (grant_idx),
        .any_req_o (any_req)
    );

    // Split the flat request bus into per-channel bytes.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Zero-latency pass-through between the owner and the decoder.
    always_comb begin
        in_req           = (state_q == REQ_HDR) || (state_q == REQ_BODY);
        in_rsp           = (state_q == RSP_HDR) || (state_q == RSP_BODY);
        req_ready        = '0;
        dec_input_data   = '0;
        dec_input_valid  = 1'b0;
        rsp_data         = '0;
        rsp_valid        = '0;
        dec_output_ready = 1'b0;
        if (in_req) begin
            dec_input_data     = req_bytes[owner_q];
            dec_input_valid    = req_valid[owner_q];
            req_ready[owner_q] = dec_input_ready;
        end
        if (in_rsp) begin
            rsp_data           = dec_output_data;
            rsp_valid[owner_q] = dec_output_valid;
            dec_output_ready   = rsp_ready[owner_q];
        end
    end

    assign req_xfer = dec_input_valid && dec_input_ready;
    assign rsp_xfer = dec_output_valid && dec_output_ready;
    assign rr_next  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Transaction FSM: grant, count request frame, count response frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
            if (state_q != RSP_HDR) begin
                tmo_q <= '0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= grant_idx;
                        busy_q  <= 1'b1;
                        state_q <= REQ_HDR;
                    end
                end
                REQ_HDR: begin
                    if (req_xfer) begin
                        cnt_q   <= dec_input_data;
                        state_q <= (dec_input_data == '0) ? RSP_HDR : REQ_BODY;
                    end
                end
                REQ_BODY: begin
                    if (req_xfer) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == FRAME_LEN_WIDTH'(1)) begin
                            state_q <= RSP_HDR;
                        end
                    end
                end
                RSP_HDR: begin
                    if (rsp_xfer) begin
                        cnt_q <= dec_output_data;
                        if (dec_output_data == '0) begin
                            rr_ptr_q <= rr_next;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= RSP_BODY;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_q <= 1'b1;
                        rr_ptr_q      <= rr_next;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                RSP_BODY: begin
                    if (rsp_xfer) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == FRAME_LEN_WIDTH'(1)) begin
                            rr_ptr_q <= rr_next;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign owner = owner_q;
    assign busy  = busy_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
